pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32, divider latency in cycles; legal range 2..63.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_ID_data_related_conflict  input  1  load-use conflict flag from the GPR bypass unit.
REQ-005 i_ID_uses_hilo  input  1  ID instruction reads HI/LO or is a mul/div.
REQ-006 i_EXE_div_issue  input  1  EXE holds a divide that wants to start.
REQ-007 i_EXE_branch_mispredict  input  1  EXE resolved a mispredicted branch.
REQ-008 i_MEM_mem_req  input  1  MEM stage is performing a data-memory access.
REQ-009 i_dmem_ready  input  1  data memory completes the access this cycle.
REQ-010 i_MEM_exception  input  1  MEM stage raises a precise exception.
REQ-011 o_PC_stall, o_IF_ID_stall, o_ID_EXE_stall, o_EXE_MEM_stall, o_MEM_WB_stall  output  1 each  hold the named register.
REQ-012 o_IF_ID_flush, o_ID_EXE_flush, o_EXE_MEM_flush, o_MEM_WB_flush  output  1 each  load a bubble into the named register.
REQ-013 o_PC_load_vector  output  1  PC loads the exception vector.
REQ-014 o_div_start  output  1  one-cycle divider start pulse.
REQ-015 o_div_abort  output  1  one-cycle divider cancel pulse.
REQ-016 o_hilo_busy  output  1  divider is running.
REQ-017 o_stall_cycles  output  32  count of cycles with o_PC_stall=1.

Function
REQ-018 The FSM SHALL have two states: RUN and DIV; a 6-bit down-counter div_cnt SHALL be used in DIV.
REQ-019 Stall/flush outputs SHALL be combinational from state and inputs, taking effect in the same cycle as the condition (zero latency).
REQ-020 Priority SHALL be exception > dmem wait > mispredict > HI/LO hazard > load-use; only the highest active condition drives outputs.
REQ-021 Exception: flush IF/ID, ID/EXE and EXE/MEM; assert o_PC_load_vector; no stalls. In DIV, also assert o_div_abort and go to RUN with div_cnt=0.
REQ-022 Dmem wait (i_MEM_mem_req=1, i_dmem_ready=0): stall PC, IF/ID, ID/EXE and EXE/MEM; flush MEM/WB; o_div_start is suppressed.
REQ-023 Mispredict: flush IF/ID and ID/EXE; no stalls.
REQ-024 HI/LO hazard (state DIV and i_ID_uses_hilo=1): stall PC and IF/ID; flush ID/EXE.
REQ-025 Load-use (i_ID_data_related_conflict=1): stall PC and IF/ID; flush ID/EXE; valid in either state.
REQ-026 o_div_start SHALL pulse for one cycle when all of the following hold: state RUN, i_EXE_div_issue=1, no exception, no dmem wait. The FSM then goes to DIV with div_cnt=DIV_CYCLES-1.
REQ-027 In DIV, div_cnt SHALL decrement each cycle, including stalled cycles. When div_cnt=0 the FSM SHALL return to RUN on the next edge. o_hilo_busy=1 exactly while in DIV.
REQ-028 i_EXE_div_issue SHALL be ignored in DIV; this case cannot occur legally, because REQ-024 holds mul/div in ID.
REQ-029 o_stall_cycles SHALL increment on each edge where o_PC_stall=1, wrapping from 0xFFFFFFFF to 0.
REQ-030 With no condition active, all stall, flush and pulse outputs SHALL be 0.

Reset
REQ-031 Asserting reset SHALL immediately force state RUN, div_cnt=0 and o_stall_cycles=0. o_hilo_busy and o_div_abort SHALL read 0; a divide in flight is dropped without an abort pulse.
REQ-032 Reset SHALL not gate the combinational stall/flush outputs; they continue to follow the inputs during reset.
REQ-033 On the first edge after reset deassertion, the block SHALL operate normally.

Verification
REQ-034 Load-use: i_ID_data_related_conflict=1 for 1 cycle -> o_PC_stall=o_IF_ID_stall=o_ID_EXE_flush=1 that cycle; o_stall_cycles goes 0->1.
REQ-035 Divide, DIV_CYCLES=32: i_EXE_div_issue pulse -> o_div_start=1 for 1 cycle, then o_hilo_busy=1 for exactly 32 cycles. i_ID_uses_hilo=1 throughout -> PC stalled those 32 cycles; stall count 32.
REQ-036 Dmem wait plus mispredict: i_MEM_mem_req=1, i_dmem_ready=0 and i_EXE_branch_mispredict=1 -> four stalls plus o_MEM_WB_flush=1, o_IF_ID_flush=0. When i_dmem_ready=1 -> IF/ID and ID/EXE flush.
REQ-037 Exception mid-divide at div_cnt=10 -> o_div_abort=1, o_PC_load_vector=1, three flushes; o_hilo_busy=0 on the next cycle.
REQ-038 Async reset mid-divide, asserted between edges -> o_hilo_busy=0 and o_stall_cycles=0 with no clock edge. Preloaded o_stall_cycles=0xFFFFFFFF plus one stall cycle -> 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central hazard controller for a 5-stage pipeline with an
//             iterative HI/LO divider. Resolves, in one cycle, which pipeline
//             registers hold or take a bubble. Priority (highest first):
//             exception, data-memory wait, branch mispredict, HI/LO hazard
//             while the divider runs, and GPR load-use conflict. It also
//             sequences the divider (start/abort pulses, busy flag) and
//             counts PC-stall cycles.
//  Ports    : clk, reset (async, active-high)
//             i_ID_data_related_conflict, i_ID_uses_hilo, i_EXE_div_issue,
//             i_EXE_branch_mispredict, i_MEM_mem_req, i_dmem_ready,
//             i_MEM_exception                           - hazard sources
//             o_*_stall / o_*_flush / o_PC_load_vector  - pipeline control
//             o_div_start, o_div_abort, o_hilo_busy     - divider control
//             o_stall_cycles[31:0]                      - PC-stall counter
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int DIV_CYCLES = 32  // divider latency, legal 2..63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ID_data_related_conflict,
  input  logic        i_ID_uses_hilo,
  input  logic        i_EXE_div_issue,
  input  logic        i_EXE_branch_mispredict,
  input  logic        i_MEM_mem_req,
  input  logic        i_dmem_ready,
  input  logic        i_MEM_exception,
  output logic        o_PC_stall,
  output logic        o_IF_ID_stall,
  output logic        o_ID_EXE_stall,
  output logic        o_EXE_MEM_stall,
  output logic        o_MEM_WB_stall,
  output logic        o_IF_ID_flush,
  output logic        o_ID_EXE_flush,
  output logic        o_EXE_MEM_flush,
  output logic        o_MEM_WB_flush,
  output logic        o_PC_load_vector,
  output logic        o_div_start,
  output logic        o_div_abort,
  output logic        o_hilo_busy,
  output logic [31:0] o_stall_cycles
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_DIV = 1'b1;

  // Counter is loaded with DIV_CYCLES-1 so that DIV lasts exactly DIV_CYCLES.
  localparam logic [5:0] C_DIV_LOAD = 6'(DIV_CYCLES - 1);

  logic [0:0]  r_state;
  logic [5:0]  r_div_cnt;
  logic [31:0] r_stall_cnt;

  logic w_in_div;
  logic w_exc;
  logic w_dwait;
  logic w_misp;
  logic w_hilo_haz;
  logic w_load_use;

  assign w_in_div   = (r_state == ST_DIV);
  assign w_exc      = i_MEM_exception;
  assign w_dwait    = i_MEM_mem_req & ~i_dmem_ready;
  assign w_misp     = i_EXE_branch_mispredict;
  assign w_hilo_haz = w_in_div & i_ID_uses_hilo;
  assign w_load_use = i_ID_data_related_conflict;

  // Only the highest-priority active condition shapes the stall/flush set.
  // Reset deliberately does not gate this block.
  always_comb begin
    o_PC_stall       = 1'b0;
    o_IF_ID_stall    = 1'b0;
    o_ID_EXE_stall   = 1'b0;
    o_EXE_MEM_stall  = 1'b0;
    o_MEM_WB_stall   = 1'b0;
    o_IF_ID_flush    = 1'b0;
    o_ID_EXE_flush   = 1'b0;
    o_EXE_MEM_flush  = 1'b0;
    o_MEM_WB_flush   = 1'b0;
    o_PC_load_vector = 1'b0;
    if (w_exc) begin
      o_IF_ID_flush    = 1'b1;
      o_ID_EXE_flush   = 1'b1;
      o_EXE_MEM_flush  = 1'b1;
      o_PC_load_vector = 1'b1;
    end else if (w_dwait) begin
      // Freeze everything up to MEM; WB gets a bubble while MEM waits.
      o_PC_stall      = 1'b1;
      o_IF_ID_stall   = 1'b1;
      o_ID_EXE_stall  = 1'b1;
      o_EXE_MEM_stall = 1'b1;
      o_MEM_WB_flush  = 1'b1;
    end else if (w_misp) begin
      o_IF_ID_flush  = 1'b1;
      o_ID_EXE_flush = 1'b1;
    end else if (w_hilo_haz || w_load_use) begin
      // Both hazards hold the ID instruction and inject an EXE bubble.
      o_PC_stall     = 1'b1;
      o_IF_ID_stall  = 1'b1;
      o_ID_EXE_flush = 1'b1;
    end
  end

  // A divide may start under a mispredict or hazard, but not when the
  // pipeline is being redirected by an exception or frozen by memory.
  assign o_div_start = ~w_in_div & i_EXE_div_issue & ~w_exc & ~w_dwait;
  assign o_div_abort = w_in_div & w_exc;
  assign o_hilo_busy = w_in_div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_div_cnt <= 6'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (o_div_start) begin
            r_state   <= ST_DIV;
            r_div_cnt <= C_DIV_LOAD;
          end
        end
        ST_DIV: begin
          if (w_exc) begin
            r_state   <= ST_RUN;
            r_div_cnt <= 6'd0;
          end else if (r_div_cnt == 6'd0) begin
            r_state <= ST_RUN;
          end else begin
            // Keeps counting through stalls: the divider is free-running.
            r_div_cnt <= r_div_cnt - 6'd1;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_div_cnt <= 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
    end else if (o_PC_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;  // natural 32-bit wrap
    end
  end

  assign o_stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl. A behavioural
//             model (busy-cycles-remaining counter plus stall tally) predicts
//             every output each cycle; directed scenarios add hand-computed
//             literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int DIV_CYCLES = 32;

  logic clk = 1'b0;
  logic reset;
  logic conf, uses_hilo, div_issue, misp, mem_req, dmem_ready, mem_exc;

  logic o_PC_stall, o_IF_ID_stall, o_ID_EXE_stall, o_EXE_MEM_stall, o_MEM_WB_stall;
  logic o_IF_ID_flush, o_ID_EXE_flush, o_EXE_MEM_flush, o_MEM_WB_flush;
  logic o_PC_load_vector, o_div_start, o_div_abort, o_hilo_busy;
  logic [31:0] o_stall_cycles;

  pipeline_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .i_ID_data_related_conflict (conf),
    .i_ID_uses_hilo             (uses_hilo),
    .i_EXE_div_issue            (div_issue),
    .i_EXE_branch_mispredict    (misp),
    .i_MEM_mem_req              (mem_req),
    .i_dmem_ready               (dmem_ready),
    .i_MEM_exception            (mem_exc),
    .o_PC_stall                 (o_PC_stall),
    .o_IF_ID_stall              (o_IF_ID_stall),
    .o_ID_EXE_stall             (o_ID_EXE_stall),
    .o_EXE_MEM_stall            (o_EXE_MEM_stall),
    .o_MEM_WB_stall             (o_MEM_WB_stall),
    .o_IF_ID_flush              (o_IF_ID_flush),
    .o_ID_EXE_flush             (o_ID_EXE_flush),
    .o_EXE_MEM_flush            (o_EXE_MEM_flush),
    .o_MEM_WB_flush             (o_MEM_WB_flush),
    .o_PC_load_vector           (o_PC_load_vector),
    .o_div_start                (o_div_start),
    .o_div_abort                (o_div_abort),
    .o_hilo_busy                (o_hilo_busy),
    .o_stall_cycles             (o_stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_busy;      // divider cycles still to run, 0 = idle
  logic [31:0] m_cnt;       // stall edges counted since reset
  logic [31:0] m_off = 32'd0; // offset applied when the bench preloads the DUT
  logic        m_run_chk = 1'b0;

  logic e_pc_st, e_ifid_st, e_idex_st, e_exmem_st, e_memwb_st;
  logic e_ifid_fl, e_idex_fl, e_exmem_fl, e_memwb_fl, e_vec, e_start, e_abort;

  always_comb begin
    e_pc_st = 0; e_ifid_st = 0; e_idex_st = 0; e_exmem_st = 0; e_memwb_st = 0;
    e_ifid_fl = 0; e_idex_fl = 0; e_exmem_fl = 0; e_memwb_fl = 0; e_vec = 0;
    if (mem_exc) begin
      e_ifid_fl = 1; e_idex_fl = 1; e_exmem_fl = 1; e_vec = 1;
    end else if (mem_req && !dmem_ready) begin
      e_pc_st = 1; e_ifid_st = 1; e_idex_st = 1; e_exmem_st = 1; e_memwb_fl = 1;
    end else if (misp) begin
      e_ifid_fl = 1; e_idex_fl = 1;
    end else if ((m_busy > 0 && uses_hilo) || conf) begin
      e_pc_st = 1; e_ifid_st = 1; e_idex_fl = 1;
    end
    e_start = (m_busy == 0) && div_issue && !mem_exc && !(mem_req && !dmem_ready);
    e_abort = (m_busy > 0) && mem_exc;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0;
      m_cnt  = 32'd0;
    end else begin
      if (e_pc_st) m_cnt = m_cnt + 32'd1;
      if (m_busy > 0) m_busy = mem_exc ? 0 : m_busy - 1;
      else if (e_start) m_busy = DIV_CYCLES;
    end
  end

  always @(negedge clk) begin
    if (m_run_chk) begin
      chk("pc_stall",     {31'd0, o_PC_stall},       {31'd0, e_pc_st});
      chk("if_id_stall",  {31'd0, o_IF_ID_stall},    {31'd0, e_ifid_st});
      chk("id_exe_stall", {31'd0, o_ID_EXE_stall},   {31'd0, e_idex_st});
      chk("exe_mem_stall",{31'd0, o_EXE_MEM_stall},  {31'd0, e_exmem_st});
      chk("mem_wb_stall", {31'd0, o_MEM_WB_stall},   32'd0);
      chk("if_id_flush",  {31'd0, o_IF_ID_flush},    {31'd0, e_ifid_fl});
      chk("id_exe_flush", {31'd0, o_ID_EXE_flush},   {31'd0, e_idex_fl});
      chk("exe_mem_flush",{31'd0, o_EXE_MEM_flush},  {31'd0, e_exmem_fl});
      chk("mem_wb_flush", {31'd0, o_MEM_WB_flush},   {31'd0, e_memwb_fl});
      chk("load_vector",  {31'd0, o_PC_load_vector}, {31'd0, e_vec});
      chk("div_start",    {31'd0, o_div_start},      {31'd0, e_start});
      chk("div_abort",    {31'd0, o_div_abort},      {31'd0, e_abort});
      chk("hilo_busy",    {31'd0, o_hilo_busy},      {31'd0, (m_busy > 0)});
      chk("stall_cycles", o_stall_cycles,            m_cnt + m_off);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic c, h, d, m, rq, rd, e);
    conf = c; uses_hilo = h; div_issue = d; misp = m;
    mem_req = rq; dmem_ready = rd; mem_exc = e;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int n;
  logic [31:0] s0;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0);
    m_run_chk = 1'b1;
    tick;
    // reset state, and combinational outputs still follow inputs in reset
    @(negedge clk);
    chk("rst_stall_cycles", o_stall_cycles, 32'd0);
    chk("rst_hilo_busy", {31'd0, o_hilo_busy}, 32'd0);
    tick;
    drive(1, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("rst_loaduse_pc_stall", {31'd0, o_PC_stall}, 32'd1);
    tick;
    drive(0, 0, 0, 0, 0, 1, 0);
    reset = 1'b0;
    tick;

    // load-use for one cycle
    drive(1, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("lu_pc_stall",   {31'd0, o_PC_stall},     32'd1);
    chk("lu_ifid_stall", {31'd0, o_IF_ID_stall},  32'd1);
    chk("lu_idex_flush", {31'd0, o_ID_EXE_flush}, 32'd1);
    chk("lu_count_before", o_stall_cycles, 32'd0);
    tick;
    drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("lu_count_after", o_stall_cycles, 32'd1);
    tick;

    // full divide with HI/LO user waiting in ID
    drive(0, 1, 1, 0, 0, 1, 0);
    @(negedge clk);
    chk("div_start_pulse", {31'd0, o_div_start}, 32'd1);
    chk("div_start_no_stall", {31'd0, o_PC_stall}, 32'd0);
    s0 = o_stall_cycles;
    tick;
    drive(0, 1, 0, 0, 0, 1, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!o_hilo_busy) break;
      n++;
      tick;
    end
    chk("div_busy_cycles", n, 32'd32);
    chk("div_stall_delta", o_stall_cycles - s0, 32'd32);
    tick;
    drive(0, 0, 0, 0, 0, 1, 0);
    tick;

    // dmem wait beats mispredict, then mispredict alone
    drive(0, 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    chk("dw_exmem_stall",  {31'd0, o_EXE_MEM_stall}, 32'd1);
    chk("dw_memwb_flush",  {31'd0, o_MEM_WB_flush},  32'd1);
    chk("dw_ifid_flush",   {31'd0, o_IF_ID_flush},   32'd0);
    tick;
    drive(0, 0, 0, 1, 1, 1, 0);
    @(negedge clk);
    chk("mp_ifid_flush",   {31'd0, o_IF_ID_flush},   32'd1);
    chk("mp_idex_flush",   {31'd0, o_ID_EXE_flush},  32'd1);
    chk("mp_pc_stall",     {31'd0, o_PC_stall},      32'd0);
    tick;

    // exception at div_cnt=10 (22nd busy cycle)
    drive(0, 0, 1, 0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (21) tick;
    drive(0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("exc_abort",      {31'd0, o_div_abort},      32'd1);
    chk("exc_vector",     {31'd0, o_PC_load_vector}, 32'd1);
    chk("exc_exmem_flush",{31'd0, o_EXE_MEM_flush},  32'd1);
    tick;
    drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("exc_busy_after", {31'd0, o_hilo_busy}, 32'd0);
    tick;

    // start-suppression corner cases
    drive(0, 0, 1, 0, 0, 1, 1);
    @(negedge clk);
    chk("exc_blocks_start", {31'd0, o_div_start}, 32'd0);
    tick;
    drive(0, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    chk("dw_blocks_start", {31'd0, o_div_start}, 32'd0);
    tick;
    drive(0, 0, 1, 1, 0, 1, 0);
    @(negedge clk);
    chk("mp_allows_start", {31'd0, o_div_start}, 32'd1);
    tick;
    // in DIV: mispredict outranks HI/LO and load-use; issue ignored
    drive(1, 1, 1, 1, 0, 1, 0);
    @(negedge clk);
    chk("div_mp_pc_stall", {31'd0, o_PC_stall}, 32'd0);
    chk("div_issue_ignored", {31'd0, o_div_start}, 32'd0);
    tick;
    drive(1, 0, 0, 0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (33) tick;

    // async reset mid-divide, between edges
    drive(0, 0, 1, 0, 0, 1, 0);
    tick;
    drive(0, 1, 0, 0, 0, 1, 0);
    repeat (5) tick;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_busy",  {31'd0, o_hilo_busy}, 32'd0);
    chk("areset_abort", {31'd0, o_div_abort}, 32'd0);
    chk("areset_count", o_stall_cycles, 32'd0);
    tick;
    drive(0, 0, 0, 0, 0, 1, 0);
    reset = 1'b0;
    tick;

    // counter wrap from all-ones
    tick;
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    m_off = 32'hFFFF_FFFF - m_cnt;
    #1 release dut.r_stall_cnt;
    drive(1, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("wrap_preload", o_stall_cycles, 32'hFFFF_FFFF);
    tick;
    drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("wrap_zero", o_stall_cycles, 32'd0);
    tick;
    tick;

    m_run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
